// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule walker: emits round keys NR down to 0.
// Optional AES_INV_KEY_ZERO_IDLE_EN blanks round_key while key_valid is low.
module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done,
    output logic [31:0]  sbox_addr,
    input  logic [31:0]  sbox_data
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    function automatic logic [7:0] f_rc(input int n);
        logic [7:0] rc;
        rc = 8'h01;
        unique case (n)
            1:       rc = 8'h01;
            2:       rc = 8'h02;
            3:       rc = 8'h04;
            4:       rc = 8'h08;
            5:       rc = 8'h10;
            6:       rc = 8'h20;
            7:       rc = 8'h40;
            8:       rc = 8'h80;
            9:       rc = 8'h1B;
            10:      rc = 8'h36;
            default: rc = 8'h01;
        endcase
        return rc;
    endfunction

    localparam logic [3:0] LP_NR      = 4'(NR);
    localparam logic [7:0] LP_RC_INIT = f_rc(NR);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic [7:0]   r_rcon;
    logic         r_done;

    logic         w_load;
    logic         w_step;
    logic         w_finish;
    logic         w_valid;

    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [31:0]  w_p0;
    logic [31:0]  w_p1;
    logic [31:0]  w_p2;
    logic [31:0]  w_p3;
    logic [127:0] w_prev;
    logic [7:0]   w_rcon_nxt;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    // Undo the forward XOR chain; only p0 needs the S-box
    assign w_p3   = w_w3 ^ w_w2;
    assign w_p2   = w_w2 ^ w_w1;
    assign w_p1   = w_w1 ^ w_w0;
    assign w_p0   = w_w0 ^ sbox_data ^ {r_rcon, 24'h0};
    assign w_prev = {w_p0, w_p1, w_p2, w_p3};

    assign sbox_addr = {w_p3[23:0], w_p3[31:24]};

    // Inverse of xtime over GF(2^8)
    assign w_rcon_nxt = r_rcon[0]
                      ? (((r_rcon ^ 8'h1B) >> 1) | 8'h80)
                      : (r_rcon >> 1);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_EMIT;
                    w_load      = 1'b1;
                end
            end
            S_EMIT: begin
                if (key_ready) begin
                    if (r_idx == 4'd0) begin
                        w_state_nxt = S_IDLE;
                        w_finish    = 1'b1;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_idx   <= '0;
            r_rcon  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            if (w_load) begin
                r_key  <= last_key;
                r_idx  <= LP_NR;
                r_rcon <= LP_RC_INIT;
            end else if (w_step) begin
                r_key  <= w_prev;
                r_idx  <= r_idx - 4'd1;
                r_rcon <= w_rcon_nxt;
            end
        end
    end

    assign w_valid   = (r_state == S_EMIT);
    assign key_valid = w_valid;
    assign busy      = w_valid;
    assign done      = r_done;
    assign round_idx = r_idx;

`ifdef AES_INV_KEY_ZERO_IDLE_EN
    assign round_key = w_valid ? r_key : 128'h0;
`else
    assign round_key = r_key;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: forward key expansion model, GF(2^8) S-box.
// Honours AES_INV_KEY_ZERO_IDLE_EN for the idle round_key expectation.
module tb_aes_inv_key_sched;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;
    logic [31:0]  sbox_addr;
    logic [31:0]  sbox_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] m_keys [0:10];

    always #5 clk = ~clk;

    aes_inv_key_sched #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done),
        .sbox_addr (sbox_addr),
        .sbox_data (sbox_data)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h0;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h0;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                   ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign sbox_data = subword(sbox_addr);

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Standard forward AES-128 expansion from the cipher key
    task automatic build_model(input logic [127:0] k0);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        m_keys[0] = k0;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            {w0, w1, w2, w3} = m_keys[r-1];
            t  = subword({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            m_keys[r] = {w0, w1, w2, w3};
            rc = gmul(rc, 8'h02);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        key_ready = 1'b0;
        last_key = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            round_idx !== 4'd0 || round_key !== 128'h0) begin
            n_fail++;
            $display("FAIL reset: v=%b b=%b d=%b idx=%0d key=%h",
                     key_valid, busy, done, round_idx, round_key);
        end
        rst = 1'b0;
    endtask

    task automatic test_known_vector();
        int hs;
        int done_cyc;
        int extra;
        build_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        hs = 0;
        done_cyc = -1;
        extra = 0;
        @(negedge clk);
        start = 1'b1;
        last_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) begin
                if (done_cyc < 0) done_cyc = c;
                else extra++;
            end
            if (key_valid === 1'b1 && hs <= NR) begin
                n_checks++;
                if (round_idx !== 4'(NR - hs) ||
                    round_key !== m_keys[NR-hs]) begin
                    n_fail++;
                    $display("FAIL kv_seq: idx=%0d key=%h want %0d %h",
                             round_idx, round_key, NR - hs, m_keys[NR-hs]);
                end
                if (hs == 1) begin
                    n_checks++;
                    if (round_key !== 128'hac7766f319fadc2128d12941575c006e) begin
                        n_fail++;
                        $display("FAIL kv_r9: got %h", round_key);
                    end
                end
                if (hs == NR) begin
                    n_checks++;
                    if (round_key !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
                        n_fail++;
                        $display("FAIL kv_r0: got %h", round_key);
                    end
                end
                hs++;
            end
        end
        n_checks++;
        if (done_cyc != NR + 2 || extra != 0 || hs != NR + 1) begin
            n_fail++;
            $display("FAIL kv_timing: done_cyc=%0d extra=%0d hs=%0d want %0d 0 %0d",
                     done_cyc, extra, hs, NR + 2, NR + 1);
        end
    endtask

    task automatic test_random_ready(input int walks);
        int hs;
        logic seen;
        logic pv;
        logic pr;
        logic [127:0] pk;
        logic [3:0] pi;
        for (int w = 0; w < walks; w++) begin
            build_model(rand128());
            @(negedge clk);
            start = 1'b1;
            last_key = m_keys[NR];
            key_ready = 1'b0;
            @(negedge clk);
            start = 1'b0;
            last_key = rand128();
            hs = 0;
            seen = 1'b0;
            pv = 1'b0;
            pr = 1'b0;
            pk = '0;
            pi = '0;
            for (int c = 0; c < 200 && !seen; c++) begin
                if (c > 0) @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
                if (pv && !pr) begin
                    n_checks++;
                    if (round_key !== pk || round_idx !== pi ||
                        key_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_hold: idx=%0d key=%h want %0d %h",
                                 round_idx, round_key, pi, pk);
                    end
                end
                if (key_valid === 1'b1) begin
                    n_checks++;
                    if (hs > NR) begin
                        n_fail++;
                        $display("FAIL rnd_extra: idx=%0d after %0d keys",
                                 round_idx, hs);
                    end else if (round_idx !== 4'(NR - hs) ||
                                 round_key !== m_keys[NR-hs]) begin
                        n_fail++;
                        $display("FAIL rnd_key: idx=%0d key=%h want %0d %h",
                                 round_idx, round_key, NR - hs, m_keys[NR-hs]);
                    end
                end
                pv = key_valid;
                pk = round_key;
                pi = round_idx;
                key_ready = ($urandom_range(0, 3) != 0);
                pr = key_ready;
                if (key_valid === 1'b1 && key_ready) hs++;
            end
            n_checks++;
            if (!seen || hs != NR + 1) begin
                n_fail++;
                $display("FAIL rnd_end: done_seen=%b hs=%0d want 1 %0d",
                         seen, hs, NR + 1);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_pulse: done=%b busy=%b want 0 0", done, busy);
            end
        end
    endtask

    task automatic test_fixed_stall();
        int hs;
        logic seen;
        logic stalled;
        logic [127:0] sk;
        build_model(rand128());
        @(negedge clk);
        start = 1'b1;
        last_key = m_keys[NR];
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        seen = 1'b0;
        stalled = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            if (!stalled && key_valid === 1'b1 && round_idx === 4'd5) begin
                stalled = 1'b1;
                key_ready = 1'b0;
                sk = round_key;
                repeat (3) begin
                    @(negedge clk);
                    n_checks++;
                    if (round_key !== sk || round_idx !== 4'd5 ||
                        key_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall5: idx=%0d key=%h want 5 %h",
                                 round_idx, round_key, sk);
                    end
                end
                key_ready = 1'b1;
            end
            if (key_valid === 1'b1 && hs <= NR) begin
                n_checks++;
                if (round_idx !== 4'(NR - hs) || round_key !== m_keys[NR-hs]) begin
                    n_fail++;
                    $display("FAIL stall_seq: idx=%0d key=%h want %0d %h",
                             round_idx, round_key, NR - hs, m_keys[NR-hs]);
                end
                hs++;
            end
        end
        n_checks++;
        if (!seen || !stalled || hs != NR + 1) begin
            n_fail++;
            $display("FAIL stall_end: done=%b stalled=%b hs=%0d", seen, stalled, hs);
        end
    endtask

    task automatic test_start_ignored();
        int hs;
        int done_cyc;
        build_model(rand128());
        @(negedge clk);
        start = 1'b1;
        last_key = m_keys[NR];
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        done_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == 4 || c == 5);
            last_key = rand128();
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (key_valid === 1'b1 && hs <= NR) begin
                n_checks++;
                if (round_idx !== 4'(NR - hs) || round_key !== m_keys[NR-hs]) begin
                    n_fail++;
                    $display("FAIL busy_start: idx=%0d key=%h want %0d %h",
                             round_idx, round_key, NR - hs, m_keys[NR-hs]);
                end
                hs++;
            end
        end
        start = 1'b0;
        n_checks++;
        if (done_cyc != NR + 2 || hs != NR + 1) begin
            n_fail++;
            $display("FAIL busy_timing: done_cyc=%0d hs=%0d want %0d %0d",
                     done_cyc, hs, NR + 2, NR + 1);
        end
    endtask

    task automatic test_reset_mid();
        logic hit;
        int ndone;
        build_model(rand128());
        @(negedge clk);
        start = 1'b1;
        last_key = m_keys[NR];
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (c > 0) @(negedge clk);
            if (key_valid === 1'b1 && round_idx === 4'd4) hit = 1'b1;
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        n_checks++;
        if (!hit || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            round_key !== 128'h0 || round_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid: hit=%b v=%b b=%b d=%b idx=%0d key=%h",
                     hit, key_valid, busy, done, round_idx, round_key);
        end
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || key_valid === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL rst_residue: %0d active cycles, want 0", ndone);
        end
    endtask

    task automatic test_idle_hold();
        logic seen;
        logic [127:0] want;
        build_model(rand128());
        @(negedge clk);
        start = 1'b1;
        last_key = m_keys[NR];
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
`ifdef AES_INV_KEY_ZERO_IDLE_EN
        want = 128'h0;
`else
        want = m_keys[0];
`endif
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (!seen || round_key !== want || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_key: seen=%b v=%b key=%h want %h",
                         seen, key_valid, round_key, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic seen;
        build_model(rand128());
        @(negedge clk);
        start = 1'b1;
        last_key = m_keys[NR];
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        build_model(rand128());
        start = 1'b1;
        last_key = m_keys[NR];
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (!seen || key_valid !== 1'b1 || round_idx !== 4'(NR) ||
            round_key !== m_keys[NR]) begin
            n_fail++;
            $display("FAIL b2b: seen=%b v=%b idx=%0d key=%h want %h",
                     seen, key_valid, round_idx, round_key, m_keys[NR]);
        end
        @(negedge clk);
        n_checks++;
        if (round_idx !== 4'(NR - 1) || round_key !== m_keys[NR-1]) begin
            n_fail++;
            $display("FAIL b2b_step: idx=%0d key=%h want %h",
                     round_idx, round_key, m_keys[NR-1]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_fixed_stall();
        test_start_ignored();
        test_reset_mid();
        test_random_ready(5);
        test_idle_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; legal range 1..10.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin walk; sampled only while busy=0.
REQ-005 SHALL have port last_key  input  128  round-NR key; word w0 = [127:96].
REQ-006 SHALL have port key_ready  input  1  consumer accepts round_key this cycle.
REQ-007 SHALL have port round_key  output  128  current round key, same word order as last_key.
REQ-008 SHALL have port round_idx  output  4  round number of round_key.
REQ-009 SHALL have port key_valid  output  1  round_key/round_idx valid.
REQ-010 SHALL have port busy  output  1  walk in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse after round 0 is accepted.
REQ-012 SHALL have port sbox_addr  output  32  four byte addresses to the external S-box.
REQ-013 SHALL have port sbox_data  input  32  combinational S-box result for sbox_addr, byte-aligned.

Function
REQ-014 SHALL implement FSM IDLE -> EMIT -> IDLE; DONE is not a state.
REQ-015 IDLE: start=1 SHALL latch last_key, load round_idx=NR, load rcon=RC[NR], enter EMIT, and set busy=1 on the next edge.
REQ-016 EMIT SHALL hold key_valid=1, and round_key and round_idx SHALL stay stable while key_ready=0.
REQ-017 In EMIT, key_ready=1 with round_idx>0 SHALL load the previous key on that edge, decrement round_idx by 1 and step rcon. Throughput is one key per cycle.
REQ-018 Previous key from {w0,w1,w2,w3}: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^{rcon,24'h0}.
REQ-019 sbox_addr SHALL equal RotWord(p3) = {p3[23:0],p3[31:24]}, derived combinationally from the current key register. SubWord SHALL be sbox_data.
REQ-020 rcon step is the inverse of xtime: if bit0=0 then rcon>>1, else ((rcon^8'h1B)>>1)|8'h80. For NR=10 the sequence is 36,1B,80,40,20,10,08,04,02,01.
REQ-021 RC[NR] SHALL be an internal 10-entry constant: 01,02,04,08,10,20,40,80,1B,36 for NR=1..10.
REQ-022 In EMIT, key_ready=1 with round_idx=0 SHALL return to IDLE, clear key_valid and busy, and pulse done=1 for exactly one cycle.
REQ-023 start SHALL be ignored while busy=1. last_key SHALL be sampled only on the accepting edge.
REQ-024 Total latency from start to done SHALL be NR+2 cycles with key_ready held at 1.
REQ-025 The key register SHALL be updated only on a handshake (key_valid&key_ready) or on start acceptance.

Reset
REQ-026 rst=1 SHALL force IDLE, key_valid=0, busy=0, done=0, round_idx=0 and round_key=0 on the next edge, including mid-walk. rst takes priority over start and key_ready.
REQ-027 After rst is released, the first start SHALL begin a fresh walk with no residue from the aborted walk.

Configuration
REQ-028 Macro AES_INV_KEY_ZERO_IDLE_EN defined: round_key SHALL read 128'h0 whenever key_valid=0.
REQ-029 Macro AES_INV_KEY_ZERO_IDLE_EN undefined: round_key SHALL hold the last emitted key (round 0) after done, until the next start or rst.

Verification
REQ-030 start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, NR=10, key_ready=1 -> round 10 emitted, then round 9 = ac7766f319fadc2128d12941575c006e.
REQ-031 Same stimulus -> round 0 = 2b7e151628aed2a6abf7158809cf4f3c, done pulses once at cycle 12 after start, and 11 handshakes total.
REQ-032 key_ready=0 for 3 cycles at round_idx=5 -> round_key and round_idx stay frozen, and the sequence resumes intact.
REQ-033 rst=1 asserted at round_idx=4 -> next cycle key_valid=0, busy=0, round_key=0, and no done pulse.
REQ-034 start pulsed while busy=1 with a different last_key -> ignored, and the walk output is unchanged.
REQ-035 After done, observe round_key with and without AES_INV_KEY_ZERO_IDLE_EN -> 0 when defined, 2b7e1516...4f3c when undefined.
